// File: rtl/reciprocal_float_cu.sv
// Sequencer for the single-precision reciprocal datapath: capture, exponent rewrite, CORDIC run, done/div-zero.
// Define RECIP_CU_TIMEOUT_EN to add a watchdog that aborts a CORDIC run stuck in WAIT.
module reciprocal_float_cu #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic zero_flag,
  input  logic done_cordic,
  output logic loadE,
  output logic loadM,
  output logic loadS,
  output logic selE,
  output logic start_cordic,
  output logic busy,
  output logic ready,
  output logic done,
  output logic div_zero,
  output logic timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CHECK, S_EXP, S_LAUNCH, S_WAIT, S_FIN, S_ZERO, S_TOUT
  } state_t;

  if ((1 << CNT_WIDTH) <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("CNT_WIDTH too narrow for TIMEOUT_CYCLES");
  end

  state_t state_q, state_d;
  logic   load_e_q, load_e_d;
  logic   load_m_q, load_m_d;
  logic   load_s_q, load_s_d;
  logic   sel_e_q, sel_e_d;
  logic   start_cordic_q, start_cordic_d;
  logic   busy_q, busy_d;
  logic   ready_q, ready_d;
  logic   done_q, done_d;
  logic   div_zero_q, div_zero_d;

`ifdef RECIP_CU_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 timeout_q, timeout_d;
  logic                 wd_expired;

  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);
  assign wd_expired = (cnt_inc == CNT_WIDTH'(TIMEOUT_CYCLES));

  // Counter restarts as the FSM enters WAIT and counts every WAIT cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_inc;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = S_CHECK;
      S_CHECK:  state_d = zero_flag ? S_ZERO : S_EXP;
      S_EXP:    state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (done_cordic) begin
          state_d = S_FIN;
`ifdef RECIP_CU_TIMEOUT_EN
        end else if (wd_expired) begin
          state_d = S_TOUT;
`endif
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track state_q exactly.
  always_comb begin
    load_e_d       = (state_d == S_LOAD) || (state_d == S_EXP);
    load_m_d       = (state_d == S_LOAD);
    load_s_d       = (state_d == S_LOAD);
    sel_e_d        = (state_d == S_LOAD);
    start_cordic_d = (state_d == S_LAUNCH);
    busy_d         = (state_d != S_IDLE);
    ready_d        = (state_d == S_IDLE);
    done_d         = (state_d == S_FIN) || (state_d == S_ZERO) || (state_d == S_TOUT);
    div_zero_d     = (state_d == S_ZERO);
`ifdef RECIP_CU_TIMEOUT_EN
    timeout_d      = (state_d == S_TOUT);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      load_e_q       <= 1'b0;
      load_m_q       <= 1'b0;
      load_s_q       <= 1'b0;
      sel_e_q        <= 1'b0;
      start_cordic_q <= 1'b0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b1;
      done_q         <= 1'b0;
      div_zero_q     <= 1'b0;
`ifdef RECIP_CU_TIMEOUT_EN
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      load_e_q       <= load_e_d;
      load_m_q       <= load_m_d;
      load_s_q       <= load_s_d;
      sel_e_q        <= sel_e_d;
      start_cordic_q <= start_cordic_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      done_q         <= done_d;
      div_zero_q     <= div_zero_d;
`ifdef RECIP_CU_TIMEOUT_EN
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
`endif
    end
  end

  assign loadE        = load_e_q;
  assign loadM        = load_m_q;
  assign loadS        = load_s_q;
  assign selE         = sel_e_q;
  assign start_cordic = start_cordic_q;
  assign busy         = busy_q;
  assign ready        = ready_q;
  assign done         = done_q;
  assign div_zero     = div_zero_q;
`ifdef RECIP_CU_TIMEOUT_EN
  assign timeout      = timeout_q;
`else
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_reciprocal_float_cu.sv
// Randomized bench for reciprocal_float_cu: each run is expanded into the expected per-cycle output trace.
module tb_reciprocal_float_cu;

  localparam int TOUT = 64;

  // Output vector: {loadE,loadM,loadS,selE,start_cordic,busy,ready,done,div_zero,timeout}
  localparam logic [9:0] V_IDLE   = 10'b0000_0_0_1_000;
  localparam logic [9:0] V_LOAD   = 10'b1111_0_1_0_000;
  localparam logic [9:0] V_BUSY   = 10'b0000_0_1_0_000;
  localparam logic [9:0] V_EXP    = 10'b1000_0_1_0_000;
  localparam logic [9:0] V_LAUNCH = 10'b0000_1_1_0_000;
  localparam logic [9:0] V_FIN    = 10'b0000_0_1_0_100;
  localparam logic [9:0] V_ZERO   = 10'b0000_0_1_0_110;
  localparam logic [9:0] V_TOUT   = 10'b0000_0_1_0_101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start, zero_flag, done_cordic;
  logic loadE, loadM, loadS, selE, start_cordic, busy, ready, done, div_zero, timeout;
  logic [9:0] obs;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_q[$];
  int         role_q[$];

  always #5 clk = ~clk;

  reciprocal_float_cu #(.TIMEOUT_CYCLES(TOUT), .CNT_WIDTH(7)) dut (
    .clk(clk), .rst(rst), .start(start), .zero_flag(zero_flag), .done_cordic(done_cordic),
    .loadE(loadE), .loadM(loadM), .loadS(loadS), .selE(selE), .start_cordic(start_cordic),
    .busy(busy), .ready(ready), .done(done), .div_zero(div_zero), .timeout(timeout)
  );

  assign obs = {loadE, loadM, loadS, selE, start_cordic, busy, ready, done, div_zero, timeout};

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // role: 0 = free cycle, 1 = CHECK (zero_flag decides), 100+k = k-th WAIT cycle
  task automatic run(input bit zero, input int n, input bit wd, input int hold_in, input string tag);
    int  len, last, hold, r;
    bit  hang;
    hang = 1'b0;
    exp_q.delete();
    role_q.delete();
    exp_q.push_back(V_LOAD); role_q.push_back(0);
    exp_q.push_back(V_BUSY); role_q.push_back(1);
    if (zero) begin
      exp_q.push_back(V_ZERO); role_q.push_back(0);
    end else begin
      exp_q.push_back(V_EXP);    role_q.push_back(0);
      exp_q.push_back(V_LAUNCH); role_q.push_back(0);
      if (wd) begin
`ifdef RECIP_CU_TIMEOUT_EN
        for (int k = 1; k <= TOUT; k++) begin
          exp_q.push_back(V_BUSY); role_q.push_back(100 + k);
        end
        exp_q.push_back(V_TOUT); role_q.push_back(0);
`else
        for (int k = 1; k <= 150; k++) begin
          exp_q.push_back(V_BUSY); role_q.push_back(100 + k);
        end
        hang = 1'b1;
`endif
      end else begin
        for (int k = 1; k <= n; k++) begin
          exp_q.push_back(V_BUSY); role_q.push_back(100 + k);
        end
        exp_q.push_back(V_FIN); role_q.push_back(0);
      end
    end
    len  = exp_q.size();
    hold = (hold_in < 0) ? int'($urandom_range(1, len + 1)) : hold_in;
    last = hang ? len - 1 : len;
    $display("run %s zero=%0d n=%0d wd=%0d hold=%0d", tag, zero, n, wd, hold);
    for (int j = 0; j <= last; j++) begin
      r = (j == 0) ? -1 : role_q[j-1];
      start     = (j == 0) ? 1'b1 : (j < hold);
      zero_flag = (r == 1) ? zero : 1'($urandom_range(0, 1));
      if (r >= 100) done_cordic = !wd && (r - 100 == n);
      else          done_cordic = 1'($urandom_range(0, 1));
      step();
      chk(tag, obs, (j < len) ? exp_q[j] : V_IDLE);
    end
    start = 1'b0;
    if (hang) begin
      chk({tag, "_to"}, {9'b0, timeout}, 10'b0);
      rst = 1'b0;
      #1;
      chk({tag, "_rst"}, obs, V_IDLE);
      step();
      rst = 1'b1;
    end
  endtask

  task automatic reset_mid_wait();
    $display("run rst_mid_wait");
    start = 1'b1; zero_flag = 1'b0; done_cordic = 1'b0;
    step(); chk("rmw_load", obs, V_LOAD);
    start = 1'b0;
    step(); chk("rmw_check", obs, V_BUSY);
    step(); chk("rmw_exp", obs, V_EXP);
    step(); chk("rmw_launch", obs, V_LAUNCH);
    step(); chk("rmw_wait", obs, V_BUSY);
    step(); chk("rmw_wait", obs, V_BUSY);
    rst = 1'b0;
    #1;
    chk("rmw_async", obs, V_IDLE);
    done_cordic = 1'b1;
    step(); chk("rmw_held", obs, V_IDLE);
    rst = 1'b1;
    step(); chk("rmw_rel", obs, V_IDLE);
    done_cordic = 1'b0;
    step(); chk("rmw_idle", obs, V_IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int gap;
    start = 1'b0; zero_flag = 1'b0; done_cordic = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = ~start;
      done_cordic = 1'($urandom_range(0, 1));
      step();
      chk("reset", obs, V_IDLE);
    end
    start = 1'b0; done_cordic = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle", obs, V_IDLE);
    end

    run(1'b0, 26, 1'b0, 1, "normal26");
    run(1'b1, 0, 1'b0, 1, "zero");
    run(1'b0, 36, 1'b0, 40, "hold40");
    reset_mid_wait();
    run(1'b0, 1, 1'b0, 1, "min_wait");
    run(1'b0, TOUT, 1'b0, 3, "race_limit");
    run(1'b1, 0, 1'b0, 4, "zero_hold");

    for (int i = 0; i < 30; i++) begin
      run($urandom_range(0, 3) == 0, int'($urandom_range(1, TOUT)), 1'b0, -1, $sformatf("rnd%0d", i));
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        zero_flag = 1'($urandom_range(0, 1));
        done_cordic = 1'($urandom_range(0, 1));
        step();
        chk("gap", obs, V_IDLE);
      end
    end

    run(1'b0, 0, 1'b1, 1, "watchdog");
    step();
    chk("post_wd", obs, V_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
